// File: rtl/median9_sorter_pkg.sv
// Shared constants for the 3x3 median sorter: window geometry and index widths.
package median9_sorter_pkg;

  localparam int unsigned WIN_SIZE       = 9;
  localparam int unsigned MED_POS        = 4;
  localparam int unsigned IDX_W          = 4;
  localparam int unsigned DEFAULT_DATA_W = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;

endpackage

// File: rtl/median9_sorter_if.sv
// Sample-in / median-out bundle between the window address path and the median sorter.
interface median9_sorter_if
  import median9_sorter_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned NUM_WIN = 16
);

  localparam int unsigned WIN_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  logic              in_start;
  logic              in_valid;
  logic              in_eff;
  logic [IDX_W-1:0]  in_idx;
  logic [DATA_W-1:0] in_data;
  logic              o_valid;
  logic [DATA_W-1:0] o_median;
  logic [WIN_W-1:0]  o_win_idx;
  logic              o_done;
  logic              o_err;

  modport master (
    output in_start, in_valid, in_eff, in_idx, in_data,
    input  o_valid, o_median, o_win_idx, o_done, o_err
  );

  modport slave (
    input  in_start, in_valid, in_eff, in_idx, in_data,
    output o_valid, o_median, o_win_idx, o_done, o_err
  );

endinterface

// File: rtl/median9_sorter_ins_cell.sv
// One slot of the insertion-sort array: next value of s[i] when v is inserted.
module median9_ins_cell #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] v,
  input  logic [DATA_W-1:0] s_cur,
  input  logic [DATA_W-1:0] s_prev,
  input  logic              is_first,
  input  logic              load_max,
  output logic [DATA_W-1:0] s_next
);

  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] prev;

  // load_max inserts into a freshly cleared array in the same cycle.
  always_comb begin
    cur  = load_max ? '1 : s_cur;
    prev = load_max ? '1 : s_prev;
    if (v >= cur) begin
      s_next = cur;
    end else if (is_first || (v >= prev)) begin
      s_next = v;
    end else begin
      s_next = prev;
    end
  end

endmodule

// File: rtl/median9_sorter.sv
// Streaming 3x3 median: insertion-sorts each window's nine padded samples and emits s[4].
module median9_sorter
  import median9_sorter_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned NUM_WIN = 16
) (
  input logic             clk,
  input logic             rst_n,
  median9_sorter_if.slave bus
);

  localparam int unsigned WIN_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(NUM_WIN - 1);

  logic [DATA_W-1:0] s_q   [WIN_SIZE];
  logic [DATA_W-1:0] s_d   [WIN_SIZE];
  logic [DATA_W-1:0] s_ins [WIN_SIZE];

  logic [IDX_W-1:0]  exp_q, exp_d;
  logic [WIN_W-1:0]  cnt_q, cnt_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [DATA_W-1:0] median_q, median_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] v;
  logic              live;
  logic              fresh;

  assign v     = bus.in_eff ? bus.in_data : '0;
  assign live  = bus.in_valid && !bus.in_start;
  assign fresh = live && (bus.in_idx == '0);

  for (genvar i = 0; i < WIN_SIZE; i++) begin : g_cell
    logic [DATA_W-1:0] prev;
    if (i == 0) begin : g_first
      assign prev = '1;
    end else begin : g_rest
      assign prev = s_q[i-1];
    end

    median9_ins_cell #(
      .DATA_W(DATA_W)
    ) u_cell (
      .v       (v),
      .s_cur   (s_q[i]),
      .s_prev  (prev),
      .is_first(i == 0),
      .load_max(fresh),
      .s_next  (s_ins[i])
    );
  end

  always_comb begin
    s_d      = s_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    median_d = median_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;

    if (bus.in_start) begin
      cnt_d = '0;
      err_d = 1'b0;
      exp_d = '0;
      for (int i = 0; i < WIN_SIZE; i++) s_d[i] = '1;
    end else if (live) begin
      if (bus.in_idx == exp_q) begin
        if (exp_q == LAST_IDX) begin
          valid_d  = 1'b1;
          median_d = s_ins[MED_POS];
          win_d    = cnt_q;
          exp_d    = '0;
          for (int i = 0; i < WIN_SIZE; i++) s_d[i] = '1;
          if (cnt_q == LAST_WIN) begin
            done_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          s_d   = s_ins;
          exp_d = exp_q + 1'b1;
        end
      end else begin
        err_d = 1'b1;
        // An out-of-order idx 0 still opens a new window.
        if (fresh) begin
          s_d   = s_ins;
          exp_d = IDX_W'(1);
        end else begin
          exp_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_SIZE; i++) s_q[i] <= '1;
      exp_q    <= '0;
      cnt_q    <= '0;
      win_q    <= '0;
      median_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_q      <= s_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      median_q <= median_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_median  = median_q;
  assign bus.o_win_idx = win_q;
  assign bus.o_done    = done_q;
  assign bus.o_err     = err_q;

endmodule
